// File: rtl/coprosit_issue_queue.sv
// Coprosit issue stage: decodes offloaded instructions, buffers accepted
// ones and releases each to the posit unit once the core commits it.
module coprosit_issue_queue #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [31:0]     issue_instr_i,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic [31:0]     issue_rs1_i,
    output logic            issue_accept_o,
    output logic            issue_writeback_o,
    output logic            issue_loadstore_o,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [4:0]      out_op_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [11:0]     out_imm_o,
    output logic [31:0]     out_rs1val_o,
    output logic [ID_W-1:0] out_id_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [6:0] OPC = 7'b0101011;

    logic [4:0]      f5, f_rd, f_rs1, f_rs2;
    logic [2:0]      f3;
    logic            opc_ok, is_plw, is_psw, is_fp;
    logic            rs2z, rs1z, rdz, z_ok;
    logic            dec_ok, dec_wb;
    logic [4:0]      dec_op;
    logic [11:0]     dec_imm;

    assign f5     = issue_instr_i[31:27];
    assign f_rs2  = issue_instr_i[24:20];
    assign f_rs1  = issue_instr_i[19:15];
    assign f3     = issue_instr_i[14:12];
    assign f_rd   = issue_instr_i[11:7];
    assign opc_ok = issue_instr_i[6:0] == OPC;
    assign is_plw = opc_ok && f3 == 3'b101;
    assign is_psw = opc_ok && f3 == 3'b110;
    assign is_fp  = opc_ok && f3 == 3'b111 &&
                    issue_instr_i[26:25] == 2'b10 && f5 <= 5'd27;

    // Some ops reuse register slots that must be encoded as x0.
    assign rs2z = f5 == 5'd6 || (f5 >= 5'd9 && f5 <= 5'd19) ||
                  f5 == 5'd23 || f5 == 5'd24;
    assign rs1z = f5 >= 5'd9 && f5 <= 5'd11;
    assign rdz  = f5 >= 5'd7 && f5 <= 5'd10;
    assign z_ok = !(rs2z && f_rs2 != 5'd0) &&
                  !(rs1z && f_rs1 != 5'd0) &&
                  !(rdz && f_rd != 5'd0);

    always_comb begin
        dec_ok  = 1'b0;
        dec_op  = '0;
        dec_imm = '0;
        unique case (1'b1)
            is_plw: begin
                dec_ok  = 1'b1;
                dec_op  = 5'd28;
                dec_imm = issue_instr_i[31:20];
            end
            is_psw: begin
                dec_ok  = 1'b1;
                dec_op  = 5'd29;
                dec_imm = {issue_instr_i[31:25], issue_instr_i[11:7]};
            end
            is_fp: begin
                dec_ok = z_ok;
                dec_op = f5;
            end
            default: ;
        endcase
    end

    assign dec_wb = dec_op inside {5'd12, 5'd13, 5'd14, 5'd15,
                                   5'd23, 5'd25, 5'd26, 5'd27};

    assign issue_accept_o    = issue_valid_i & dec_ok;
    assign issue_writeback_o = issue_accept_o & dec_wb;
    assign issue_loadstore_o = issue_accept_o & (is_plw | is_psw);

    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     cnt;
    logic [DEPTH-1:0] vld, cmt, kil;
    logic [4:0]      op_q  [DEPTH];
    logic [4:0]      rd_q  [DEPTH];
    logic [4:0]      rs1_q [DEPTH];
    logic [4:0]      rs2_q [DEPTH];
    logic [11:0]     imm_q [DEPTH];
    logic [31:0]     val_q [DEPTH];
    logic [ID_W-1:0] id_q  [DEPTH];
    logic            full, push, pop, drop, hit_new;

    assign full          = cnt == (AW+1)'(DEPTH);
    assign issue_ready_o = !full;
    assign push          = issue_valid_i & issue_ready_o & dec_ok;
    assign hit_new       = commit_valid_i && commit_id_i == issue_id_i;

    // A killed head is retired internally without ever being offered.
    assign out_valid_o = vld[rptr] & cmt[rptr] & ~kil[rptr];
    assign drop        = vld[rptr] & cmt[rptr] & kil[rptr];
    assign pop         = (out_valid_o & out_ready_i) | drop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            vld  <= '0;
            cmt  <= '0;
            kil  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                rd_q[i]  <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                imm_q[i] <= '0;
                val_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (!push && pop) cnt <= cnt - 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wptr == AW'(i)) begin
                    op_q[i]  <= dec_op;
                    rd_q[i]  <= f_rd;
                    rs1_q[i] <= f_rs1;
                    rs2_q[i] <= f_rs2;
                    imm_q[i] <= dec_imm;
                    val_q[i] <= issue_rs1_i;
                    id_q[i]  <= issue_id_i;
                    vld[i]   <= 1'b1;
                    cmt[i]   <= hit_new;
                    kil[i]   <= hit_new & commit_kill_i;
                end else if (vld[i] && commit_valid_i &&
                             id_q[i] == commit_id_i) begin
                    cmt[i] <= 1'b1;
                    kil[i] <= commit_kill_i;
                end
                if (pop && rptr == AW'(i)) vld[i] <= 1'b0;
            end
        end
    end

    assign out_op_o     = out_valid_o ? op_q[rptr]  : '0;
    assign out_rd_o     = out_valid_o ? rd_q[rptr]  : '0;
    assign out_rs1_o    = out_valid_o ? rs1_q[rptr] : '0;
    assign out_rs2_o    = out_valid_o ? rs2_q[rptr] : '0;
    assign out_imm_o    = out_valid_o ? imm_q[rptr] : '0;
    assign out_rs1val_o = out_valid_o ? val_q[rptr] : '0;
    assign out_id_o     = out_valid_o ? id_q[rptr]  : '0;

endmodule
